// File: rtl/i2c_init_sequencer_pkg.sv
// Shared constants for the boot-time I2C register loader: table entry layout,
// FSM state encoding and helpers for building table entries.
package i2c_init_sequencer_pkg;

   localparam int ENTRY_W        = 17;
   localparam int DELAY_FLAG_BIT = 16;
   localparam int FIELD_W        = 8;
   localparam int REG_LSB        = 8;
   localparam int DATA_LSB       = 0;
   localparam int MS_W           = 16;

   typedef logic [ENTRY_W-1:0] entry_t;

   typedef enum logic [3:0] {
      ST_POWERUP,
      ST_FETCH,
      ST_ISSUE,
      ST_WAIT,
      ST_GAP,
      ST_DELAY,
      ST_NEXT,
      ST_DONE,
      ST_ERROR
   } state_e;

   function automatic entry_t mk_write(input logic [FIELD_W-1:0] reg_addr,
                                       input logic [FIELD_W-1:0] value);
      return {1'b0, reg_addr, value};
   endfunction

   function automatic entry_t mk_delay(input logic [MS_W-1:0] ms);
      return {1'b1, ms};
   endfunction

endpackage

// File: rtl/i2c_init_rom.sv
// Board-specific register table (HDMI transmitter bring-up) with a registered
// read port; indices at or beyond ENTRY_COUNT read back as a 0 ms delay.
module i2c_init_rom
   import i2c_init_sequencer_pkg::*;
#(
   parameter int unsigned ENTRY_COUNT = 16
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic [7:0]   index,
   output logic [16:0]  entry
);

   entry_t entry_d, entry_q;

   always_comb begin
      entry_d = mk_delay(16'd0);
      if (int'(index) < int'(ENTRY_COUNT)) begin
         case (index)
            8'd0:    entry_d = mk_write(8'h41, 8'h10);   // power up the transmitter
            8'd1:    entry_d = mk_delay(16'd3);          // let the PLL settle
            8'd2:    entry_d = mk_write(8'h98, 8'h03);
            8'd3:    entry_d = mk_write(8'h9A, 8'hE0);
            8'd4:    entry_d = mk_write(8'h9C, 8'h30);
            8'd5:    entry_d = mk_write(8'h9D, 8'h61);
            8'd6:    entry_d = mk_write(8'hA2, 8'hA4);
            8'd7:    entry_d = mk_write(8'hA3, 8'hA4);
            8'd8:    entry_d = mk_write(8'hE0, 8'hD0);
            8'd9:    entry_d = mk_write(8'hF9, 8'h00);
            8'd10:   entry_d = mk_write(8'h15, 8'h00);
            8'd11:   entry_d = mk_write(8'h16, 8'h30);
            8'd12:   entry_d = mk_write(8'h17, 8'h02);
            8'd13:   entry_d = mk_write(8'h18, 8'h46);
            8'd14:   entry_d = mk_write(8'hAF, 8'h06);
            8'd15:   entry_d = mk_write(8'hD6, 8'hC0);
            default: entry_d = mk_delay(16'd0);
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) entry_q <= '0;
      else          entry_q <= entry_d;
   end

   assign entry = entry_q;

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks the register table after a power-up delay, issuing one I2C write per
// entry with NACK retry, and reports done/error to downstream enable logic.
module i2c_init_sequencer
   import i2c_init_sequencer_pkg::*;
#(
   parameter int unsigned CLOCK_FREQUENCY   = 50_000_000,
   parameter logic [6:0]  DEVICE_ADDRESS    = 7'h39,
   parameter int unsigned ENTRY_COUNT       = 16,
   parameter int unsigned MAX_RETRIES       = 3,
   parameter int unsigned POWER_UP_DELAY_MS = 10
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         restart,
   output logic         master_ready,
   output logic [6:0]   master_address,
   output logic         master_rw,
   output logic [7:0]   master_register,
   output logic [7:0]   master_data,
   input  logic         master_valid,
   input  logic         master_nack,
   output logic         busy,
   output logic         done,
   output logic         error,
   output logic [7:0]   error_index
);

   localparam int unsigned      CYC_PER_MS  = CLOCK_FREQUENCY / 1000;
   localparam int unsigned      TICK_W      = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
   localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(CYC_PER_MS - 1);
   localparam logic [7:0]       LAST_INDEX  = 8'(ENTRY_COUNT - 1);
   localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);
   localparam logic [MS_W-1:0]  PU_MS       = MS_W'(POWER_UP_DELAY_MS);

   state_e              state_d, state_q;
   logic [7:0]          idx_d, idx_q;
   logic [3:0]          retry_d, retry_q;
   logic [MS_W-1:0]     dly_d, dly_q;
   logic [TICK_W-1:0]   tick_d, tick_q;
   logic                ready_d, ready_q;
   logic [7:0]          reg_d, reg_q;
   logic [7:0]          data_d, data_q;
   logic                busy_d, busy_q;
   logic                done_d, done_q;
   logic                err_d, err_q;
   logic [7:0]          eidx_d, eidx_q;

   logic                tick;
   logic                wait_over;
   logic [16:0]         rom_entry;

   // ROM is addressed with the next index so the entry is already registered
   // during the single FETCH cycle (and stays put across GAP retries).
   i2c_init_rom #(
      .ENTRY_COUNT (ENTRY_COUNT)
   ) u_rom (
      .clock   (clock),
      .reset_n (reset_n),
      .index   (idx_d),
      .entry   (rom_entry)
   );

   assign tick      = (tick_q == '0);
   assign wait_over = (dly_q == '0) || (tick && (dly_q == MS_W'(1)));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      retry_d = retry_q;
      dly_d   = dly_q;
      tick_d  = tick ? TICK_RELOAD : tick_q - TICK_W'(1);
      ready_d = 1'b0;
      reg_d   = reg_q;
      data_d  = data_q;
      done_d  = done_q;
      err_d   = err_q;
      eidx_d  = eidx_q;

      case (state_q)
         ST_POWERUP: begin
            if (wait_over) begin
               state_d = ST_FETCH;
               idx_d   = '0;
               retry_d = '0;
            end else if (tick) begin
               dly_d = dly_q - MS_W'(1);
            end
         end
         ST_FETCH: begin
            if (rom_entry[DELAY_FLAG_BIT]) begin
               state_d = ST_DELAY;
               dly_d   = rom_entry[MS_W-1:0];
               tick_d  = TICK_RELOAD;
            end else begin
               state_d = ST_ISSUE;
               ready_d = 1'b1;
               reg_d   = rom_entry[REG_LSB +: FIELD_W];
               data_d  = rom_entry[DATA_LSB +: FIELD_W];
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (master_valid) begin
               if (!master_nack) begin
                  state_d = ST_NEXT;
               end else if (retry_q < RETRY_LIMIT) begin
                  state_d = ST_GAP;
                  retry_d = retry_q + 4'd1;
                  dly_d   = MS_W'(1);
                  tick_d  = TICK_RELOAD;
               end else begin
                  state_d = ST_ERROR;
                  err_d   = 1'b1;
                  eidx_d  = idx_q;
               end
            end
         end
         ST_GAP: begin
            if (wait_over) begin
               state_d = ST_ISSUE;
               ready_d = 1'b1;
               reg_d   = rom_entry[REG_LSB +: FIELD_W];
               data_d  = rom_entry[DATA_LSB +: FIELD_W];
            end else if (tick) begin
               dly_d = dly_q - MS_W'(1);
            end
         end
         ST_DELAY: begin
            if (wait_over)   state_d = ST_NEXT;
            else if (tick)   dly_d   = dly_q - MS_W'(1);
         end
         ST_NEXT: begin
            if (idx_q == LAST_INDEX) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               state_d = ST_FETCH;
               idx_d   = idx_q + 8'd1;
               retry_d = '0;
            end
         end
         ST_DONE, ST_ERROR: begin
            if (restart) begin
               state_d = ST_FETCH;
               idx_d   = '0;
               retry_d = '0;
               done_d  = 1'b0;
               err_d   = 1'b0;
               eidx_d  = '0;
            end
         end
         default: state_d = ST_POWERUP;
      endcase

      busy_d = !((state_d == ST_DONE) || (state_d == ST_ERROR));
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_POWERUP;
         idx_q   <= '0;
         retry_q <= '0;
         dly_q   <= PU_MS;
         tick_q  <= TICK_RELOAD;
         ready_q <= 1'b0;
         reg_q   <= '0;
         data_q  <= '0;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         eidx_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         retry_q <= retry_d;
         dly_q   <= dly_d;
         tick_q  <= tick_d;
         ready_q <= ready_d;
         reg_q   <= reg_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         eidx_q  <= eidx_d;
      end
   end

   assign master_ready    = ready_q;
   assign master_address  = DEVICE_ADDRESS;
   assign master_rw       = 1'b0;
   assign master_register = reg_q;
   assign master_data     = data_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign error           = err_q;
   assign error_index     = eidx_q;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Bench for the I2C init sequencer: 4 ms-cycle clock, 4-entry table
// (write, 3 ms delay, write, write), scoreboarded requests with a 5-cycle master.
module tb_i2c_init_sequencer;

   localparam int CLK_HZ  = 4000;
   localparam int ENTRIES = 4;
   localparam int RETRIES = 2;
   localparam int PU_MS   = 2;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       restart = 1'b0;
   logic       master_valid = 1'b0;
   logic       master_nack = 1'b0;
   logic       master_ready, master_rw, busy, done, error;
   logic [6:0] master_address;
   logic [7:0] master_register, master_data, error_index;

   int cyc;
   int errors = 0;
   int checks = 0;
   int stray_at = -1;

   typedef struct { int run; logic [7:0] rg; logic [7:0] dt; int off; bit nack; } vec_t;
   typedef struct { logic [7:0] rg; logic [7:0] dt; int cyc; bit nack; } exp_t;

   vec_t vec[12];
   exp_t sb[$];

   always #5 clock = ~clock;

   i2c_init_sequencer #(
      .CLOCK_FREQUENCY   (CLK_HZ),
      .DEVICE_ADDRESS    (7'h39),
      .ENTRY_COUNT       (ENTRIES),
      .MAX_RETRIES       (RETRIES),
      .POWER_UP_DELAY_MS (PU_MS)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .restart         (restart),
      .master_ready    (master_ready),
      .master_address  (master_address),
      .master_rw       (master_rw),
      .master_register (master_register),
      .master_data     (master_data),
      .master_valid    (master_valid),
      .master_nack     (master_nack),
      .busy            (busy),
      .done            (done),
      .error           (error),
      .error_index     (error_index)
   );

   // cyc == k after the k-th rising edge following reset release
   always @(posedge clock or negedge reset_n)
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   // master model + scoreboard pop: respond 5 cycles after each request
   bit   pend = 0;
   int   due = 0;
   bit   pnack = 0;
   always @(negedge clock) begin
      exp_t e;
      master_valid = 1'b0;
      if (!reset_n) begin
         pend = 0;
      end else begin
         if (pend && cyc == due - 1) begin
            master_valid = 1'b1;
            master_nack  = pnack;
            pend = 0;
         end
         if (cyc == stray_at) begin
            master_valid = 1'b1;
            master_nack  = 1'b0;
         end
         if (master_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_req: request reg=0x%0h at cycle %0d, none expected",
                        master_register, cyc);
            end else begin
               e = sb.pop_front();
               chk("req_cycle", cyc, e.cyc);
               chk("req_reg", master_register, e.rg);
               chk("req_data", master_data, e.dt);
               chk("req_addr", master_address, 7'h39);
               chk("req_rw", master_rw, 1'b0);
               pend  = 1;
               due   = cyc + 5;
               pnack = e.nack;
            end
         end
      end
   end

   task automatic push_run(input int run, input int s);
      foreach (vec[i])
         if (vec[i].run == run)
            sb.push_back('{vec[i].rg, vec[i].dt, s + vec[i].off, vec[i].nack});
   endtask

   task automatic wait_end(input string name, input int exp_cyc);
      int n = 0;
      while (!(done || error) && n < 300) begin
         @(negedge clock);
         n++;
      end
      chk(name, cyc, exp_cyc);
   endtask

   task automatic pulse_restart(output int s);
      @(negedge clock);
      restart = 1'b1;
      s = cyc + 1;
      @(negedge clock);
      restart = 1'b0;
   endtask

   initial begin
      int s;
      // offsets are relative to the edge that enters FETCH for entry 0
      vec = '{
         '{0, 8'h41, 8'h10,  1, 1'b0},
         '{0, 8'h98, 8'h03, 22, 1'b0},
         '{0, 8'h9A, 8'hE0, 29, 1'b0},
         '{1, 8'h41, 8'h10,  1, 1'b0},
         '{1, 8'h98, 8'h03, 22, 1'b1},
         '{1, 8'h98, 8'h03, 31, 1'b1},
         '{1, 8'h98, 8'h03, 40, 1'b0},
         '{1, 8'h9A, 8'hE0, 47, 1'b0},
         '{2, 8'h41, 8'h10,  1, 1'b0},
         '{2, 8'h98, 8'h03, 22, 1'b1},
         '{2, 8'h98, 8'h03, 31, 1'b1},
         '{2, 8'h98, 8'h03, 40, 1'b1}
      };

      repeat (2) @(negedge clock);
      #1;
      chk("rst_ready", master_ready, 1'b0);
      chk("rst_reg", master_register, 8'h00);
      chk("rst_data", master_data, 8'h00);
      chk("rst_busy", busy, 1'b1);
      chk("rst_done", done, 1'b0);
      chk("rst_error", error, 1'b0);
      chk("rst_eidx", error_index, 8'h00);
      @(negedge clock);
      reset_n = 1'b1;

      // run 0: power-up 2 ms, all ACK; stray master_valid during the delay
      push_run(0, 8);
      stray_at = 22;
      while (cyc < 20) @(negedge clock);
      chk("mid_busy", busy, 1'b1);
      chk("mid_done", done, 1'b0);
      wait_end("run0_end_cycle", 43);
      chk("run0_done", done, 1'b1);
      chk("run0_busy", busy, 1'b0);
      chk("run0_error", error, 1'b0);
      chk("run0_sb_empty", sb.size(), 0);
      stray_at = -1;

      // run 1: entry 2 NACKed twice then ACKed; restart while busy ignored
      pulse_restart(s);
      push_run(1, s);
      chk("rs1_done_clr", done, 1'b0);
      chk("rs1_busy", busy, 1'b1);
      repeat (11) @(negedge clock);
      restart = 1'b1;
      @(negedge clock);
      restart = 1'b0;
      wait_end("retry_end_cycle", s + 53);
      chk("retry_done", done, 1'b1);
      chk("retry_error", error, 1'b0);
      chk("retry_sb_empty", sb.size(), 0);

      // run 2: entry 2 always NACKed, retries exhausted
      pulse_restart(s);
      push_run(2, s);
      wait_end("err_end_cycle", s + 45);
      chk("err_error", error, 1'b1);
      chk("err_index", error_index, 8'd2);
      chk("err_done", done, 1'b0);
      chk("err_busy", busy, 1'b0);
      repeat (30) @(negedge clock);
      chk("err_hold", error, 1'b1);
      chk("err_sb_empty", sb.size(), 0);

      // restart from ERROR, then reset while waiting on entry 0
      pulse_restart(s);
      chk("rs3_error_clr", error, 1'b0);
      push_run(0, s);
      while (cyc < s + 3) @(negedge clock);
      chk("wait_reg", master_register, 8'h41);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_ready", master_ready, 1'b0);
      chk("mid_rst_busy", busy, 1'b1);
      chk("mid_rst_done", done, 1'b0);
      chk("mid_rst_reg", master_register, 8'h00);
      chk("mid_rst_data", master_data, 8'h00);
      sb.delete();
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      push_run(0, 8);
      wait_end("rerun_end_cycle", 43);
      chk("rerun_done", done, 1'b1);
      chk("rerun_sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
